// File: rtl/ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: port ids, response tag, default sizes.
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RD_LAT_DEF = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One slot of the read-return pipeline: a read is in flight and which port issued it.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/ram_1port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the last granted port is remembered.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  logic       r_last_grant;
  logic [1:0] w_gnt;

  // Pick a requester. On contention, the port that was not granted last time wins.
  always_comb begin
    w_gnt = 2'b00;
    if (!i_rst) begin
      unique case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_last_grant == PORT1) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign o_gnt_c = w_gnt;

  // Remember the most recently granted port; reset favours port 0 on first contention.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= PORT1;
    end else if (|w_gnt) begin
      r_last_grant <= w_gnt[1] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/ram_1port_arbiter.sv
// Shares one single-port RAM between two request ports: round-robin arbitration,
// registered RAM controls and a tag pipeline that steers read data back to its issuer.
module ram_1port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
)(
  input  logic              sys_clk,
  input  logic              sys_rst,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rsp_valid,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rsp_valid,

  output logic [DATA_W-1:0] rsp_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);

  // One extra stage covers the RAM control register in front of the macro.
  localparam int unsigned TAG_D = RD_LAT + 1;

  logic [1:0]        w_gnt;
  logic              w_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  tag_t              w_tag_in;
  tag_t [TAG_D-1:0]  r_tag;

  rr_arb2 u_arb (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_req   ({p1_valid, p0_valid}),
    .o_gnt_c (w_gnt)
  );

  assign p0_ready = w_gnt[0];
  assign p1_ready = w_gnt[1];

  // Select the accepted request's fields; at most one grant is active.
  assign w_acc   = |w_gnt;
  assign w_we    = w_gnt[1] ? p1_we    : p0_we;
  assign w_addr  = w_gnt[1] ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt[1] ? p1_wdata : p0_wdata;

  // Register the accepted access toward the RAM; address and data hold when idle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      ram_rden  <= 1'b0;
    end else if (w_acc) begin
      ram_addr  <= w_addr;
      ram_wdata <= w_wdata;
      ram_wren  <= w_we;
      ram_rden  <= ~w_we;
    end else begin
      ram_wren  <= 1'b0;
      ram_rden  <= 1'b0;
    end
  end

  assign w_tag_in.vld = w_acc & ~w_we;
  assign w_tag_in.id  = w_gnt[1];

  // Track in-flight reads so each response lands on the port that issued it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[TAG_D-2:0], w_tag_in};
    end
  end

  assign p0_rsp_valid = r_tag[TAG_D-1].vld & (r_tag[TAG_D-1].id == PORT0);
  assign p1_rsp_valid = r_tag[TAG_D-1].vld & (r_tag[TAG_D-1].id == PORT1);
  assign rsp_rdata    = ram_q;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Directed bench for ram_1port_arbiter with a behavioural RAM of read latency 2.
module tb_ram_1port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned RL = 2;

  logic          sys_clk;
  logic          sys_rst;
  logic          p0_valid, p0_ready, p0_we, p0_rsp_valid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p1_valid, p1_ready, p1_we, p1_rsp_valid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren, ram_rden;
  logic [DW-1:0] ram_q;

  int checks;
  int failures;

  ram_1port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_q(ram_q)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // RAM model: write on the sampling edge, read data appears RL cycles after sampling.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q1, q2;
  always @(posedge sys_clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) q1 <= mem[ram_addr];
    q2 <= q1;
  end
  assign ram_q = q2;

  task automatic test_reset();
    p0_valid = 1'b1; p1_valid = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (p0_ready !== 1'b0) begin failures++; $display("FAIL reset_p0_ready got=%b exp=0", p0_ready); end
    checks++; if (p1_ready !== 1'b0) begin failures++; $display("FAIL reset_p1_ready got=%b exp=0", p1_ready); end
    checks++; if ({ram_wren, ram_rden} !== 2'b00) begin failures++; $display("FAIL reset_ram_en got=%b exp=00", {ram_wren, ram_rden}); end
    checks++; if ({ram_addr, ram_wdata} !== 16'h0000) begin failures++; $display("FAIL reset_ram_addr_data got=%h exp=0000", {ram_addr, ram_wdata}); end
    checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", {p0_rsp_valid, p1_rsp_valid}); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  task automatic test_write();
    @(posedge sys_clk); #1;
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 8'h5A;
    @(negedge sys_clk);
    checks++; if ({p0_ready, p1_ready} !== 2'b10) begin failures++; $display("FAIL write_ready got=%b exp=10", {p0_ready, p1_ready}); end
    @(posedge sys_clk); #1;
    p0_valid = 1'b0; p0_we = 1'b0;
    @(negedge sys_clk);
    checks++; if ({ram_wren, ram_rden} !== 2'b10) begin failures++; $display("FAIL write_ram_en got=%b exp=10", {ram_wren, ram_rden}); end
    checks++; if ({ram_addr, ram_wdata} !== 16'h105A) begin failures++; $display("FAIL write_ram_addr_data got=%h exp=105a", {ram_addr, ram_wdata}); end
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin failures++; $display("FAIL write_no_rsp c=%0d got=%b exp=00", c, {p0_rsp_valid, p1_rsp_valid}); end
    end
  endtask

  task automatic test_preload();
    logic [7:0] a [8];
    logic [7:0] d [8];
    a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23};
    d = '{8'h30, 8'h31, 8'h32, 8'h33, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i <= 8; i++) begin
      @(posedge sys_clk); #1;
      if (i < 8) begin
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = a[i]; p0_wdata = d[i];
      end else begin
        p0_valid = 1'b0; p0_we = 1'b0;
      end
      @(negedge sys_clk);
      if (i < 8) begin
        checks++; if (p0_ready !== 1'b1) begin failures++; $display("FAIL preload_ready i=%0d got=%b exp=1", i, p0_ready); end
      end
      if (i > 0) begin
        checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, a[i-1], d[i-1]}) begin
          failures++; $display("FAIL preload_ram i=%0d got=%b/%h/%h exp=1/%h/%h", i, ram_wren, ram_addr, ram_wdata, a[i-1], d[i-1]);
        end
      end
    end
    repeat (3) @(posedge sys_clk);
  endtask

  task automatic test_read_p1();
    @(posedge sys_clk); #1;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
    @(negedge sys_clk);
    checks++; if ({p0_ready, p1_ready} !== 2'b01) begin failures++; $display("FAIL rd1_ready got=%b exp=01", {p0_ready, p1_ready}); end
    for (int c = 1; c <= 5; c++) begin
      @(posedge sys_clk); #1;
      p1_valid = 1'b0;
      @(negedge sys_clk);
      if (c == 1) begin
        checks++; if ({ram_rden, ram_wren, ram_addr} !== {2'b10, 8'h10}) begin failures++; $display("FAIL rd1_ram got=%b%b/%h exp=10/10", ram_rden, ram_wren, ram_addr); end
      end
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== {1'b0, c == 3}) begin failures++; $display("FAIL rd1_rsp c=%0d got=%b exp=%b", c, {p0_rsp_valid, p1_rsp_valid}, {1'b0, c == 3}); end
      if (c == 3) begin
        checks++; if (rsp_rdata !== 8'h5A) begin failures++; $display("FAIL rd1_data got=%h exp=5a", rsp_rdata); end
      end
    end
  endtask

  task automatic test_contention();
    bit   [7:0] rdy0, rdy1, rv0, rv1;
    logic [7:0] ed [8];
    rdy0 = 8'b0000_0101; rdy1 = 8'b0000_1010;
    rv0  = 8'b0010_1000; rv1  = 8'b0101_0000;
    ed   = '{8'h00, 8'h00, 8'h00, 8'h30, 8'h32, 8'h31, 8'h33, 8'h00};
    for (int c = 0; c < 8; c++) begin
      @(posedge sys_clk); #1;
      p0_valid = (c <= 2); p0_we = 1'b0; p0_addr = (c == 0) ? 8'h00 : 8'h01;
      p1_valid = (c <= 3); p1_we = 1'b0; p1_addr = (c <= 1) ? 8'h02 : 8'h03;
      @(negedge sys_clk);
      checks++; if ({p0_ready, p1_ready} !== {rdy0[c], rdy1[c]}) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, {p0_ready, p1_ready}, {rdy0[c], rdy1[c]}); end
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== {rv0[c], rv1[c]}) begin failures++; $display("FAIL rr_rsp c=%0d got=%b exp=%b", c, {p0_rsp_valid, p1_rsp_valid}, {rv0[c], rv1[c]}); end
      if (rv0[c] || rv1[c]) begin
        checks++; if (rsp_rdata !== ed[c]) begin failures++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, rsp_rdata, ed[c]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit   [15:0] rdy0, rv0;
    logic [7:0]  ed [16];
    rdy0 = 16'h000F; rv0 = 16'h0078;
    for (int i = 0; i < 16; i++) ed[i] = 8'h00;
    ed[3] = 8'hA0; ed[4] = 8'hA1; ed[5] = 8'hA2; ed[6] = 8'hA3;
    for (int c = 0; c < 9; c++) begin
      @(posedge sys_clk); #1;
      p0_valid = (c <= 3); p0_we = 1'b0; p0_addr = 8'h20 + 8'(c);
      p1_valid = 1'b0;
      @(negedge sys_clk);
      checks++; if ({p0_ready, p1_ready} !== {rdy0[c], 1'b0}) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b0", c, {p0_ready, p1_ready}, rdy0[c]); end
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== {rv0[c], 1'b0}) begin failures++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b0", c, {p0_rsp_valid, p1_rsp_valid}, rv0[c]); end
      if (rv0[c]) begin
        checks++; if (rsp_rdata !== ed[c]) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, rsp_rdata, ed[c]); end
      end
    end
  endtask

  task automatic test_reset_midop();
    @(posedge sys_clk); #1;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 8'h20;
    @(negedge sys_clk);
    checks++; if (p0_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_accept got=%b exp=1", p0_ready); end
    @(posedge sys_clk); #1;
    p0_valid = 1'b0;
    checks++; if (ram_rden !== 1'b1) begin failures++; $display("FAIL rst_mid_rden_pre got=%b exp=1", ram_rden); end
    #1 sys_rst = 1'b1;
    #1;
    checks++; if ({ram_rden, ram_wren} !== 2'b00) begin failures++; $display("FAIL rst_mid_rden got=%b exp=00", {ram_rden, ram_wren}); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      checks++; if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid_no_rsp c=%0d got=%b exp=00", c, {p0_rsp_valid, p1_rsp_valid}); end
      @(posedge sys_clk); #1;
    end
    p0_valid = 1'b1; p0_addr = 8'h03;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
    @(negedge sys_clk);
    checks++; if ({p0_ready, p1_ready} !== 2'b10) begin failures++; $display("FAIL rst_mid_first_grant got=%b exp=10", {p0_ready, p1_ready}); end
    @(posedge sys_clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    repeat (6) @(posedge sys_clk);
  endtask

  task automatic test_idle();
    @(posedge sys_clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
    p0_addr = 8'h77; p1_addr = 8'h66; p0_we = 1'b1; p1_we = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      checks++; if ({ram_wren, ram_rden, p0_ready, p1_ready} !== 4'b0000) begin failures++; $display("FAIL idle_ctrl c=%0d got=%b exp=0000", c, {ram_wren, ram_rden, p0_ready, p1_ready}); end
      checks++; if (ram_addr !== 8'h03) begin failures++; $display("FAIL idle_addr c=%0d got=%h exp=03", c, ram_addr); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    sys_rst = 1'b1;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    test_reset();
    test_write();
    test_preload();
    test_read_p1();
    test_contention();
    test_back_to_back();
    test_reset_midop();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_1port_arbiter.md
Name: ram_1port_arbiter

Overview:
Round-robin arbiter and sequencer sharing one single-port RAM (ip_1port_ram style macro) between two requester ports. Accepts at most one read or write per cycle, drives registered RAM controls, and routes read data back to the issuing port using a tag pipeline matched to the RAM read latency. Sits between client logic (e.g. a data writer and a data reader) and the RAM IP.

Parameters:
ADDR_W, 8, RAM address width (256 words).
DATA_W, 8, RAM data width.
RD_LAT, 2, cycles from ram_rden/ram_addr sampled by RAM to ram_q valid; legal range 1..4.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
p0_valid  in  1  port 0 request valid
p0_ready  out  1  port 0 request accepted this cycle (combinational)
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_rsp_valid  out  1  port 0 read data valid, single-cycle pulse
p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rsp_valid  same as port 0, for port 1
rsp_rdata  out  DATA_W  read data shared by both ports, qualified by px_rsp_valid
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_wren  out  1  RAM write enable (registered)
ram_rden  out  1  RAM read enable (registered)
ram_q  in  DATA_W  RAM read data

Behaviour:
- Reset (async assert, sync release): ram_addr=0, ram_wdata=0, ram_wren=0, ram_rden=0, tag pipeline cleared, px_rsp_valid=0, RR pointer last_grant=1 (port 0 wins first contention). px_ready=0 while sys_rst high.
- Arbitration (combinational, every cycle): only p0_valid -> grant 0; only p1_valid -> grant 1; both -> grant port != last_grant; none -> no grant. px_ready=1 only for granted port. px_ready does not depend on the other port's ready.
- Accept: transfer when px_valid & px_ready in cycle T. Client must hold valid/we/addr/wdata stable until accepted.
- On accept in T: at T+1 ram_addr/ram_wdata = accepted values, ram_wren = we, ram_rden = ~we; last_grant updated to granted port. No accept: ram_wren=ram_rden=0, ram_addr/ram_wdata hold.
- Throughput: one access per cycle, no bubbles; back-to-back accepts from same port allowed when other port idle.
- Read return: tag pipeline RD_LAT+1 stages deep, entry = {valid, port id}, shifts every cycle. Read accepted at T -> px_rsp_valid high exactly at T+1+RD_LAT for issuing port only; rsp_rdata = ram_q passthrough. Writes produce no response.
- Responses cannot be back-pressured; clients must sink every rsp_valid pulse.
- Read-after-write same address, consecutive accepts: read returns new data (RAM new-data read-during-write is not exercised since port is single; ordering is strict acceptance order).
- Reset mid-operation: in-flight reads discarded, no rsp_valid after reset until new reads accepted; RAM contents not touched.
- Both valid every cycle: strict alternation 0,1,0,1...

Decomposition:
- Shared package ram_arb_pkg: PORT0/PORT1 id constants, tag struct {vld, id}, default widths.
- One sub-module natural: rr_arb2 (2-way round-robin grant with last_grant register). Tag pipeline and RAM register stage stay in top.

Test Plan:
- Port 0 writes 0x5A to addr 0x10 (p1 idle) -> p0_ready=1 at T; T+1 ram_wren=1, ram_addr=0x10, ram_wdata=0x5A; no rsp_valid.
- Port 1 reads addr 0x10 after above -> p1_rsp_valid pulse at T+3 (RD_LAT=2), rsp_rdata=0x5A; p0_rsp_valid stays 0.
- Both ports request reads continuously to 0x00..0x03 -> grants 0,1,0,1; responses alternate per port, each 3 cycles after own accept.
- Port 0 reads 4 back-to-back addrs 0x20..0x23 holding 0xA0..0xA3 -> 4 consecutive p0_rsp_valid cycles, data 0xA0..0xA3 in order.
- Assert sys_rst one cycle after read accept -> ram_rden=0 immediately, no rsp_valid ever for that read; first contention after release granted to port 0.
- All valid low for 10 cycles -> ram_wren=ram_rden=0, ram_addr unchanged, no ready asserted.
